// File: rtl/plab4_net_router_output_ctrl_tp.sv
// ============================================================================
// plab4_net_router_output_ctrl_tp
//
// Output-port controller of the timing-protected (TP) router. It owns a
// two-domain time-slot schedule, arbitrates round-robin among the west,
// terminal and east input controllers, and only grants inputs whose domain
// tag matches the current slot. The last p_guard_cycles of every slot issue
// no grants, so traffic of one domain never spills into the other's slot.
//
// Parameters
//   p_slot_cycles   cycles per domain slot (>= 2)
//   p_guard_cycles  trailing no-grant cycles per slot (< p_slot_cycles)
//   p_in_domains    domain tag per input, bit i = domain of input i
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous active-low reset
//   reqs[2:0]        request vector (0=west, 1=terminal, 2=east)
//   grants[2:0]      one-hot or zero; granted input transfers this cycle
//   out_val          a flit is presented on the output this cycle
//   out_rdy          downstream accepts the flit
//   sel[1:0]         registered crossbar select of the last winner
//   domain0/domain1  registered one-hot indication of the current slot owner
//
// Optional feature (macro PLAB4_NET_ROUTER_OUTPUT_CTRL_TP_STATS_EN):
//   xfer_cnt0[15:0]       transfers made in domain-0 slots (saturating)
//   xfer_cnt1[15:0]       transfers made in domain-1 slots (saturating)
//   guard_stall_cnt[15:0] cycles where a domain-matching request with
//                         out_rdy high was blocked only by the guard window
// ============================================================================
module plab4_net_router_output_ctrl_tp #(
    parameter int         p_slot_cycles  = 16,
    parameter int         p_guard_cycles = 2,
    parameter logic [2:0] p_in_domains   = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  reqs,
    output logic [2:0]  grants,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [1:0]  sel,
    output logic        domain0,
    output logic        domain1
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_TP_STATS_EN
   ,output logic [15:0] xfer_cnt0,
    output logic [15:0] xfer_cnt1,
    output logic [15:0] guard_stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (p_slot_cycles < 2) begin : g_bad_slot
            $error("p_slot_cycles must be >= 2");
        end
        if (p_guard_cycles < 0 || p_guard_cycles >= p_slot_cycles) begin : g_bad_guard
            $error("p_guard_cycles must be in [0, p_slot_cycles)");
        end
    endgenerate

    localparam int lp_cnt_w = (p_slot_cycles < 2) ? 1 : $clog2(p_slot_cycles);

    localparam logic [lp_cnt_w-1:0] lp_last_slot = lp_cnt_w'(p_slot_cycles - 1);

    // One extra bit: with p_guard_cycles == 0 the threshold equals
    // p_slot_cycles, which may not fit in the counter width.
    localparam logic [lp_cnt_w:0] lp_guard_start =
        (lp_cnt_w + 1)'(p_slot_cycles - p_guard_cycles);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                r_cur_dom;
    logic [lp_cnt_w-1:0] r_slot_cnt;
    logic [2:0]          r_prio;
    logic [1:0]          r_sel;
    logic                r_domain0;
    logic                r_domain1;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic       w_slot_wrap;
    logic       w_next_dom;
    logic       w_guard;
    logic [2:0] w_dom_match;
    logic [2:0] w_elig;
    logic [2:0] w_grants;
    logic [1:0] w_win_idx;

    assign w_slot_wrap = (r_slot_cnt == lp_last_slot);
    assign w_next_dom  = w_slot_wrap ? ~r_cur_dom : r_cur_dom;
    assign w_guard     = ({1'b0, r_slot_cnt} >= lp_guard_start);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_dom_match[i] = (p_in_domains[i] == r_cur_dom);
        end
    end

    // Reset is folded in so grants/out_val are zero combinationally while
    // reset is held low, regardless of stale state.
    assign w_elig = reqs & w_dom_match & {3{~w_guard & out_rdy & reset}};

    // Circular scan upward from the one-hot priority pointer.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_grants = 3'b000;
        case (r_prio)
            3'b010: begin
                if      (w_elig[1]) w_grants = 3'b010;
                else if (w_elig[2]) w_grants = 3'b100;
                else if (w_elig[0]) w_grants = 3'b001;
            end
            3'b100: begin
                if      (w_elig[2]) w_grants = 3'b100;
                else if (w_elig[0]) w_grants = 3'b001;
                else if (w_elig[1]) w_grants = 3'b010;
            end
            default: begin
                if      (w_elig[0]) w_grants = 3'b001;
                else if (w_elig[1]) w_grants = 3'b010;
                else if (w_elig[2]) w_grants = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_win_idx = 2'd0;
        if (w_grants[1]) w_win_idx = 2'd1;
        if (w_grants[2]) w_win_idx = 2'd2;
    end

    assign grants  = w_grants;
    assign out_val = |w_grants;
    assign sel     = r_sel;
    assign domain0 = r_domain0;
    assign domain1 = r_domain1;

    // ------------------------------------------------------------------
    // Schedule, pointer and select registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is sampled on the clock edge (synchronous), not in the
    // sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_dom  <= 1'b0;
            r_slot_cnt <= '0;
            r_prio     <= 3'b001;
            r_sel      <= 2'd0;
            r_domain0  <= 1'b1;
            r_domain1  <= 1'b0;
        end else begin
            r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + lp_cnt_w'(1);
            r_cur_dom  <= w_next_dom;
            // Domain outputs are their own flops tracking the next domain,
            // so they stay exactly one-hot and glitch-free.
            r_domain0  <= ~w_next_dom;
            r_domain1  <= w_next_dom;
            if (|w_grants) begin
                r_prio <= {w_grants[1:0], w_grants[2]};
                r_sel  <= w_win_idx;
            end
        end
    end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_TP_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [15:0] r_xfer_cnt0;
    logic [15:0] r_xfer_cnt1;
    logic [15:0] r_guard_stall_cnt;
    logic        w_guard_stall;

    // Would have been granted had the guard window not been active.
    assign w_guard_stall = w_guard & out_rdy & (|(reqs & w_dom_match));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xfer_cnt0       <= 16'd0;
            r_xfer_cnt1       <= 16'd0;
            r_guard_stall_cnt <= 16'd0;
        end else begin
            if ((|w_grants) && !r_cur_dom && r_xfer_cnt0 != 16'hFFFF)
                r_xfer_cnt0 <= r_xfer_cnt0 + 16'd1;
            if ((|w_grants) && r_cur_dom && r_xfer_cnt1 != 16'hFFFF)
                r_xfer_cnt1 <= r_xfer_cnt1 + 16'd1;
            if (w_guard_stall && r_guard_stall_cnt != 16'hFFFF)
                r_guard_stall_cnt <= r_guard_stall_cnt + 16'd1;
        end
    end

    assign xfer_cnt0       = r_xfer_cnt0;
    assign xfer_cnt1       = r_xfer_cnt1;
    assign guard_stall_cnt = r_guard_stall_cnt;
`endif

endmodule
